// File: rtl/register_file_writeback.sv
// RV32I integer register file with same-cycle writeback bypass and a
// per-register busy scoreboard used by issue to stall on pending results.
module register_file_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int REGISTER_COUNT = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] rs1_address,
    input  logic [ADDRESS_WIDTH-1:0] rs2_address,
    output logic [DATA_WIDTH-1:0]    rs1_value,
    output logic [DATA_WIDTH-1:0]    rs2_value,
    output logic                     operands_busy,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
    input  logic                     writeback_valid,
    input  logic [ADDRESS_WIDTH-1:0] writeback_rd,
    input  logic [DATA_WIDTH-1:0]    writeback_value,
    output logic                     writeback_error
);

    localparam logic [REGISTER_COUNT-1:0] ONE_HOT = REGISTER_COUNT'(1);

    logic [DATA_WIDTH-1:0]     r_regs [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] r_busy;

    logic                      w_wb_write;
    logic [REGISTER_COUNT-1:0] w_set_mask;
    logic [REGISTER_COUNT-1:0] w_clear_mask;
    logic [REGISTER_COUNT-1:0] w_busy_left;
    logic [REGISTER_COUNT-1:0] w_busy_next;
    logic [DATA_WIDTH-1:0]     w_src1;
    logic [DATA_WIDTH-1:0]     w_src2;
    logic                      w_operands_busy;
    logic                      w_error_hit;

    assign w_wb_write = writeback_valid && (writeback_rd != '0);

    always_comb begin
        w_set_mask = '0;
        w_clear_mask = '0;
        if (issue_valid && (issue_rd != '0))
            w_set_mask = ONE_HOT << issue_rd;
        if (w_wb_write)
            w_clear_mask = ONE_HOT << writeback_rd;
    end

    // An issue and a writeback to the same register leave it busy:
    // the newly issued producer is still outstanding.
    assign w_busy_left = r_busy & ~w_clear_mask;
    assign w_busy_next = (w_busy_left | w_set_mask) & ~ONE_HOT;

    always_comb begin
        w_src1 = r_regs[rs1_address];
        if (rs1_address == '0)
            w_src1 = '0;
        else if (w_wb_write && (writeback_rd == rs1_address))
            w_src1 = writeback_value;
    end

    always_comb begin
        w_src2 = r_regs[rs2_address];
        if (rs2_address == '0)
            w_src2 = '0;
        else if (w_wb_write && (writeback_rd == rs2_address))
            w_src2 = writeback_value;
    end

    assign w_operands_busy = w_busy_left[rs1_address] || w_busy_left[rs2_address];
    assign w_error_hit = w_wb_write && !r_busy[writeback_rd];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGISTER_COUNT; i++)
                r_regs[i] <= '0;
            r_busy          <= '0;
            rs1_value       <= '0;
            rs2_value       <= '0;
            operands_busy   <= 1'b0;
            writeback_error <= 1'b0;
        end else begin
            if (w_wb_write)
                r_regs[writeback_rd] <= writeback_value;
            r_busy <= w_busy_next;
            if (read_enable) begin
                rs1_value     <= w_src1;
                rs2_value     <= w_src2;
                operands_busy <= w_operands_busy;
            end
            if (w_error_hit)
                writeback_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_register_file_writeback.sv
// Self-checking bench for register_file_writeback: directed scenarios plus
// randomized traffic checked against an array-based reference model.
module tb_register_file_writeback;

    logic        clock;
    logic        reset;
    logic        read_enable;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        operands_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        writeback_valid;
    logic [4:0]  writeback_rd;
    logic [31:0] writeback_value;
    logic        writeback_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_ob;
    logic        m_err;

    register_file_writeback dut (
        .clock(clock),
        .reset(reset),
        .read_enable(read_enable),
        .rs1_address(rs1_address),
        .rs2_address(rs2_address),
        .rs1_value(rs1_value),
        .rs2_value(rs2_value),
        .operands_busy(operands_busy),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .writeback_valid(writeback_valid),
        .writeback_rd(writeback_rd),
        .writeback_value(writeback_value),
        .writeback_error(writeback_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 0;
        end
        m_rs1 = '0;
        m_rs2 = '0;
        m_ob = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic idle();
        read_enable = 0;
        rs1_address = 0;
        rs2_address = 0;
        issue_valid = 0;
        issue_rd = 0;
        writeback_valid = 0;
        writeback_rd = 0;
        writeback_value = 0;
    endtask

    function automatic logic [31:0] src(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (writeback_valid && writeback_rd == a) return writeback_value;
        return m_reg[a];
    endfunction

    function automatic logic pend(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (writeback_valid && writeback_rd == a) return 1'b0;
        return m_busy[a];
    endfunction

    // Predict outputs from the current inputs, clock once, then commit state.
    task automatic step();
        logic [31:0] s1, s2;
        logic ob, e;
        s1 = read_enable ? src(rs1_address) : m_rs1;
        s2 = read_enable ? src(rs2_address) : m_rs2;
        ob = read_enable ? (pend(rs1_address) || pend(rs2_address)) : m_ob;
        e = m_err || (writeback_valid && writeback_rd != 0 && !m_busy[writeback_rd]);
        @(posedge clock);
        #1;
        m_rs1 = s1;
        m_rs2 = s2;
        m_ob = ob;
        m_err = e;
        if (writeback_valid && writeback_rd != 0) begin
            m_reg[writeback_rd] = writeback_value;
            m_busy[writeback_rd] = 0;
        end
        if (issue_valid && issue_rd != 0)
            m_busy[issue_rd] = 1;
    endtask

    task automatic test_reset();
        idle();
        checks++;
        if (rs1_value !== 0 || rs2_value !== 0 || operands_busy !== 0 || writeback_error !== 0) begin
            errors++;
            $display("FAIL reset_outputs: rs1=%h rs2=%h busy=%b err=%b, required all 0",
                     rs1_value, rs2_value, operands_busy, writeback_error);
        end
        for (int i = 0; i < 32; i++) begin
            read_enable = 1;
            rs1_address = 5'(i);
            rs2_address = 5'(31 - i);
            step();
            checks++;
            if (rs1_value !== 0 || rs2_value !== 0 || operands_busy !== 0 || writeback_error !== 0) begin
                errors++;
                $display("FAIL reset_read x%0d: rs1=%h rs2=%h busy=%b err=%b, required 0",
                         i, rs1_value, rs2_value, operands_busy, writeback_error);
            end
        end
        idle();
    endtask

    task automatic test_writeback_read();
        idle();
        issue_valid = 1; issue_rd = 5;
        step();
        idle();
        writeback_valid = 1; writeback_rd = 5; writeback_value = 32'hDEADBEEF;
        step();
        idle();
        read_enable = 1; rs1_address = 5; rs2_address = 0;
        step();
        checks++;
        if (rs1_value !== 32'hDEADBEEF || operands_busy !== 0 || writeback_error !== 0) begin
            errors++;
            $display("FAIL wb_read: rs1=%h busy=%b err=%b, required deadbeef 0 0",
                     rs1_value, operands_busy, writeback_error);
        end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        issue_valid = 1; issue_rd = 7;
        step();
        idle();
        writeback_valid = 1; writeback_rd = 7; writeback_value = 32'h1234;
        read_enable = 1; rs1_address = 7; rs2_address = 7;
        step();
        checks++;
        if (rs1_value !== 32'h00001234 || rs2_value !== 32'h00001234 || operands_busy !== 0) begin
            errors++;
            $display("FAIL bypass: rs1=%h rs2=%h busy=%b, required 00001234 00001234 0",
                     rs1_value, rs2_value, operands_busy);
        end
        idle();
    endtask

    task automatic test_busy();
        idle();
        issue_valid = 1; issue_rd = 3;
        step();
        idle();
        read_enable = 1; rs1_address = 0; rs2_address = 3;
        step();
        checks++;
        if (operands_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_pending: busy=%b, required 1", operands_busy);
        end
        idle();
        issue_valid = 1; issue_rd = 3;
        writeback_valid = 1; writeback_rd = 3; writeback_value = 32'hA5A5_0003;
        step();
        idle();
        read_enable = 1; rs1_address = 3; rs2_address = 0;
        step();
        checks++;
        if (operands_busy !== 1'b1 || rs1_value !== 32'hA5A5_0003) begin
            errors++;
            $display("FAIL busy_reissue: busy=%b rs1=%h, required 1 a5a50003",
                     operands_busy, rs1_value);
        end
        // Issuing instruction reads its own sources before its set applies.
        idle();
        writeback_valid = 1; writeback_rd = 3; writeback_value = 32'h33;
        step();
        idle();
        read_enable = 1; rs1_address = 3; rs2_address = 3;
        issue_valid = 1; issue_rd = 3;
        step();
        checks++;
        if (operands_busy !== 1'b0 || writeback_error !== 1'b0) begin
            errors++;
            $display("FAIL busy_self_issue: busy=%b err=%b, required 0 0",
                     operands_busy, writeback_error);
        end
        idle();
        writeback_valid = 1; writeback_rd = 3; writeback_value = 32'h3;
        step();
        idle();
    endtask

    task automatic test_x0_and_error();
        idle();
        writeback_valid = 1; writeback_rd = 0; writeback_value = 32'hFFFFFFFF;
        step();
        idle();
        read_enable = 1; rs1_address = 0; rs2_address = 0;
        step();
        checks++;
        if (rs1_value !== 0 || rs2_value !== 0 || writeback_error !== 0) begin
            errors++;
            $display("FAIL x0_write: rs1=%h rs2=%h err=%b, required 0 0 0",
                     rs1_value, rs2_value, writeback_error);
        end
        idle();
        writeback_valid = 1; writeback_rd = 9; writeback_value = 32'hCAFE_0009;
        step();
        checks++;
        if (writeback_error !== 1'b1) begin
            errors++;
            $display("FAIL error_set: err=%b, required 1", writeback_error);
        end
        idle();
        read_enable = 1; rs1_address = 9; rs2_address = 0;
        step();
        checks++;
        if (rs1_value !== 32'hCAFE_0009 || writeback_error !== 1'b1) begin
            errors++;
            $display("FAIL error_write: rs1=%h err=%b, required cafe0009 1",
                     rs1_value, writeback_error);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            read_enable = 1'($urandom_range(0, 3) != 0);
            rs1_address = 5'($urandom_range(0, 7));
            rs2_address = 5'($urandom_range(0, 7));
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7));
            writeback_valid = 1'($urandom_range(0, 1));
            writeback_rd = 5'($urandom_range(0, 7));
            writeback_value = $urandom;
            step();
            checks++;
            if (rs1_value !== m_rs1 || rs2_value !== m_rs2 ||
                operands_busy !== m_ob || writeback_error !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: rs1=%h rs2=%h busy=%b err=%b, required %h %h %b %b",
                         n, rs1_value, rs2_value, operands_busy, writeback_error,
                         m_rs1, m_rs2, m_ob, m_err);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        writeback_valid = 1; writeback_rd = 6; writeback_value = 32'h0BAD_F00D;
        issue_valid = 1; issue_rd = 6;
        step();
        idle();
        issue_valid = 1; issue_rd = 4;
        read_enable = 1; rs1_address = 6; rs2_address = 4;
        step();
        checks++;
        if (rs1_value !== 32'h0BAD_F00D || operands_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: rs1=%h busy=%b, required 0badf00d 1",
                     rs1_value, operands_busy);
        end
        idle();
        #1 reset = 1;
        #1;
        checks++;
        if (rs1_value !== 0 || rs2_value !== 0 || operands_busy !== 0 || writeback_error !== 0) begin
            errors++;
            $display("FAIL async_reset: rs1=%h rs2=%h busy=%b err=%b, required 0",
                     rs1_value, rs2_value, operands_busy, writeback_error);
        end
        model_reset();
        #1 reset = 0;
        read_enable = 1; rs1_address = 4; rs2_address = 6;
        step();
        checks++;
        if (rs1_value !== 0 || rs2_value !== 0 || operands_busy !== 0 || writeback_error !== 0) begin
            errors++;
            $display("FAIL after_reset: rs1=%h rs2=%h busy=%b err=%b, required 0",
                     rs1_value, rs2_value, operands_busy, writeback_error);
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1;
        #12;
        test_reset();
        reset = 0;
        test_reset();
        test_writeback_read();
        test_bypass();
        test_busy();
        test_x0_and_error();
        test_random();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
